// File: rtl/march_pkg.sv
// March C- BIST shared definitions: controller states, op encoding and the
// element table (direction, op count, op list) for the six March elements.
package march_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_OP    = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } march_state_e;

   typedef enum logic [1:0] {
      OP_W0 = 2'd0,
      OP_W1 = 2'd1,
      OP_R0 = 2'd2,
      OP_R1 = 2'd3
   } march_op_e;

   typedef struct packed {
      logic      dir_up;
      logic [1:0] op_cnt;
      march_op_e op0;
      march_op_e op1;
   } march_elem_t;

   localparam int         NUM_ELEMS = 6;
   localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

   // E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 dn(r0,w1); E4 dn(r1,w0); E5 up(r0)
   function automatic march_elem_t elem_entry(input logic [2:0] idx);
      march_elem_t e;
      case (idx)
         3'd0:    e = '{dir_up: 1'b1, op_cnt: 2'd1, op0: OP_W0, op1: OP_W0};
         3'd1:    e = '{dir_up: 1'b1, op_cnt: 2'd2, op0: OP_R0, op1: OP_W1};
         3'd2:    e = '{dir_up: 1'b1, op_cnt: 2'd2, op0: OP_R1, op1: OP_W0};
         3'd3:    e = '{dir_up: 1'b0, op_cnt: 2'd2, op0: OP_R0, op1: OP_W1};
         3'd4:    e = '{dir_up: 1'b0, op_cnt: 2'd2, op0: OP_R1, op1: OP_W0};
         default: e = '{dir_up: 1'b1, op_cnt: 2'd1, op0: OP_R0, op1: OP_R0};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/march_bist_controller_element_rom.sv
// Combinational March element lookup.
//  elem_idx  in   3  element index 0..5
//  op_idx    in   1  op index within the element
//  op        out  2  op code (W0/W1/R0/R1)
//  dir_up    out  1  element address direction, 1 = ascending
//  last_op   out  1  op_idx is the last op of the element
module march_element_rom
   import march_pkg::*;
(
   input  logic [2:0] elem_idx,
   input  logic       op_idx,
   output march_op_e  op,
   output logic       dir_up,
   output logic       last_op
);

   march_elem_t e;

   always_comb begin
      e       = elem_entry(elem_idx);
      dir_up  = e.dir_up;
      op      = op_idx ? e.op1 : e.op0;
      last_op = (e.op_cnt == 2'd1) || op_idx;
   end

endmodule

// File: rtl/march_bist_controller.sv
// March C- BIST controller: steps the external address generator through six
// March elements, issues memory read/write strobes, compares read data with the
// expected background and captures the first failure.
//  clk, reset_n            clock, async active-low reset
//  start, abort            test start pulse (IDLE only), synchronous abort
//  busy, done, fail        status; fail is sticky until the next accepted start
//  fail_addr/element/data  first-failure capture
//  ag_*                    address generator controls / current address
//  mem_*                   memory strobes and data
//
// state    | meaning
// IDLE     | waiting for start
// INIT     | load address generator (reset for up, preset for down)
// OP       | one write, or the read-request half of a read
// CHECK    | compare read data returned by the previous OP
// DONE     | one-cycle done pulse
module march_bist_controller
   import march_pkg::*;
#(
   parameter int A_WIDTH      = 4,
   parameter int D_WIDTH      = 8,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [A_WIDTH-1:0] fail_addr,
   output logic [2:0]         fail_element,
   output logic [D_WIDTH-1:0] fail_data,
   output logic               ag_reset,
   output logic               ag_preset,
   output logic               ag_en,
   output logic               ag_up_down,
   input  logic [A_WIDTH-1:0] ag_address,
   output logic               mem_we,
   output logic               mem_re,
   output logic [D_WIDTH-1:0] mem_wdata,
   input  logic [D_WIDTH-1:0] mem_rdata
);

   march_state_e       state_q, state_d;
   logic [2:0]         elem_q, elem_d;
   logic               op_q, op_d;
   logic               exp_q, exp_d;
   logic               fail_q, fail_d;
   logic [A_WIDTH-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]         fail_elem_q, fail_elem_d;
   logic [D_WIDTH-1:0] fail_data_q, fail_data_d;

   march_op_e op;
   logic      dir_up, last_op, is_read, bg, terminal, mismatch, step;

   march_element_rom u_rom (
      .elem_idx (elem_q),
      .op_idx   (op_q),
      .op       (op),
      .dir_up   (dir_up),
      .last_op  (last_op)
   );

   assign is_read  = (op == OP_R0) || (op == OP_R1);
   assign bg       = (op == OP_W1) || (op == OP_R1);
   assign terminal = dir_up ? (&ag_address) : (ag_address == '0);
   assign mismatch = (mem_rdata != {D_WIDTH{exp_q}});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         elem_q      <= '0;
         op_q        <= 1'b0;
         exp_q       <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         op_q        <= op_d;
         exp_q       <= exp_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         fail_data_q <= fail_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      op_d        = op_q;
      exp_d       = exp_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      fail_data_d = fail_data_q;
      ag_reset    = 1'b0;
      ag_preset   = 1'b0;
      ag_en       = 1'b0;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_wdata   = '0;
      step        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               fail_d      = 1'b0;
               fail_addr_d = '0;
               fail_elem_d = '0;
               fail_data_d = '0;
               elem_d      = '0;
               op_d        = 1'b0;
               state_d     = ST_INIT;
            end
         end
         ST_INIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               ag_reset  = dir_up;
               ag_preset = !dir_up;
               op_d      = 1'b0;
               state_d   = ST_OP;
            end
         end
         ST_OP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (is_read) begin
               mem_re  = 1'b1;
               exp_d   = bg;
               state_d = ST_CHECK;
            end else begin
               mem_we    = 1'b1;
               mem_wdata = {D_WIDTH{bg}};
               step      = 1'b1;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               if (mismatch && !fail_q) begin
                  fail_d      = 1'b1;
                  fail_addr_d = ag_address;
                  fail_elem_d = elem_q;
                  fail_data_d = mem_rdata;
               end
               if (mismatch && STOP_ON_FAIL) state_d = ST_DONE;
               else                          step    = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Finish the current op: next op at this address, next address, or
      // (at the terminal address) the next element / end of test.
      if (step) begin
         if (last_op) begin
            op_d = 1'b0;
            if (terminal) begin
               if (elem_q == LAST_ELEM) begin
                  state_d = ST_DONE;
               end else begin
                  elem_d  = elem_q + 3'd1;
                  state_d = ST_INIT;
               end
            end else begin
               ag_en   = 1'b1;
               state_d = ST_OP;
            end
         end else begin
            op_d    = 1'b1;
            state_d = ST_OP;
         end
      end
   end

   assign busy         = (state_q == ST_INIT) || (state_q == ST_OP) || (state_q == ST_CHECK);
   assign done         = (state_q == ST_DONE);
   assign ag_up_down   = busy && dir_up;
   assign fail         = fail_q;
   assign fail_addr    = fail_addr_q;
   assign fail_element = fail_elem_q;
   assign fail_data    = fail_data_q;

endmodule

// File: tb/tb_march_bist_controller.sv
module tb_march_bist_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, start, abort, fault_en;

   logic       busy [2], done [2], fail [2];
   logic       ag_reset [2], ag_preset [2], ag_en [2], ag_up_down [2];
   logic       mem_we [2], mem_re [2];
   logic [1:0] fail_addr [2], addr [2];
   logic [2:0] fail_element [2];
   logic [7:0] fail_data [2], wdata [2], rdata [2];
   logic [7:0] mem [2][4];

   int n_cmp = 0;
   int n_fail = 0;
   int busy_tot [2] = '{0, 0};
   int done_tot [2] = '{0, 0};
   int we_after_fail = 0;
   int mutex_err = 0;
   int idle_err = 0;
   logic [1:0] ends [$];

   march_bist_controller #(.A_WIDTH(2), .D_WIDTH(8), .STOP_ON_FAIL(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .busy(busy[0]), .done(done[0]), .fail(fail[0]), .fail_addr(fail_addr[0]),
      .fail_element(fail_element[0]), .fail_data(fail_data[0]),
      .ag_reset(ag_reset[0]), .ag_preset(ag_preset[0]), .ag_en(ag_en[0]),
      .ag_up_down(ag_up_down[0]), .ag_address(addr[0]),
      .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0])
   );

   march_bist_controller #(.A_WIDTH(2), .D_WIDTH(8), .STOP_ON_FAIL(1'b1)) dut_stop (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .busy(busy[1]), .done(done[1]), .fail(fail[1]), .fail_addr(fail_addr[1]),
      .fail_element(fail_element[1]), .fail_data(fail_data[1]),
      .ag_reset(ag_reset[1]), .ag_preset(ag_preset[1]), .ag_en(ag_en[1]),
      .ag_up_down(ag_up_down[1]), .ag_address(addr[1]),
      .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1])
   );

   // Stuck-at-0 on bit 0 of address 2 when fault_en is set.
   function automatic logic [7:0] apply_fault(input logic [7:0] d, input logic [1:0] a);
      if (fault_en && a == 2'd2) return d & 8'hFE;
      return d;
   endfunction

   // Address generator and memory models, one per controller.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            addr[i]  <= 2'd0;
            rdata[i] <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (ag_reset[i])       addr[i] <= 2'd0;
            else if (ag_preset[i]) addr[i] <= 2'd3;
            else if (ag_en[i])     addr[i] <= ag_up_down[i] ? addr[i] + 2'd1 : addr[i] - 2'd1;
            if (mem_we[i]) mem[i][addr[i]] <= apply_fault(wdata[i], addr[i]);
            if (mem_re[i]) rdata[i] <= mem[i][addr[i]];
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (busy[i]) busy_tot[i]++;
         if (done[i]) done_tot[i]++;
         if (int'(ag_reset[i]) + int'(ag_preset[i]) + int'(ag_en[i]) > 1) mutex_err++;
         if (!busy[i] && (ag_reset[i] | ag_preset[i] | ag_en[i] | ag_up_down[i] |
                          mem_we[i] | mem_re[i])) idle_err++;
      end
      if (fail[1] && mem_we[1]) we_after_fail++;
      if (ag_reset[0] | ag_preset[0] | done[0]) ends.push_back(addr[0]);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name, input int limit);
      int c = 0;
      while (!done[0] && c < limit) begin
         step();
         c++;
      end
      check(name, 32'(done[0]), 32'd1);
   endtask

   function automatic logic [31:0] outs(input int i);
      return 32'({busy[i], done[i], fail[i], fail_addr[i], fail_element[i], fail_data[i],
                  ag_reset[i], ag_preset[i], ag_en[i], ag_up_down[i], mem_we[i], mem_re[i],
                  wdata[i]});
   endfunction

   // Full fault-free run from IDLE: start pulse, 66 busy cycles, one done, pass.
   task automatic run_pass(input string name);
      int b0, d0;
      b0 = busy_tot[0];
      d0 = done_tot[0];
      start = 1'b1;
      step();
      start = 1'b0;
      check({name, "_fail_clr"}, 32'(fail[0]), 32'd0);
      wait_done({name, "_done"}, 200);
      step(); step(); step();
      check({name, "_busy_cycles"}, 32'(busy_tot[0] - b0), 32'd66);
      check({name, "_done_count"}, 32'(done_tot[0] - d0), 32'd1);
      check({name, "_fail"}, 32'(fail[0]), 32'd0);
   endtask

   typedef struct {
      logic       start;
      logic [7:0] flags;  // busy,done,ag_reset,ag_preset,ag_en,ag_up_down,mem_we,mem_re
      logic [7:0] wdata;
      logic [1:0] addr;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int b0, b1, d0, d1, q0, waf, c;
      logic [1:0] exp_ends [6];

      vecs[0] = '{1'b1, 8'b1010_0100, 8'h00, 2'd0};  // E0 INIT
      vecs[1] = '{1'b0, 8'b1000_1110, 8'h00, 2'd0};  // w0 @0, advance
      vecs[2] = '{1'b0, 8'b1000_1110, 8'h00, 2'd1};
      vecs[3] = '{1'b0, 8'b1000_1110, 8'h00, 2'd2};
      vecs[4] = '{1'b0, 8'b1000_0110, 8'h00, 2'd3};  // terminal: no ag_en
      vecs[5] = '{1'b0, 8'b1010_0100, 8'h00, 2'd3};  // E1 INIT
      vecs[6] = '{1'b0, 8'b1000_0101, 8'h00, 2'd0};  // r0 @0
      vecs[7] = '{1'b0, 8'b1000_0100, 8'h00, 2'd0};  // CHECK
      vecs[8] = '{1'b0, 8'b1000_1110, 8'hFF, 2'd0};  // w1 @0, advance
      vecs[9] = '{1'b0, 8'b1000_0101, 8'h00, 2'd1};  // r0 @1
      exp_ends = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd3};

      reset_n  = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      fault_en = 1'b0;
      step(); step();
      check("reset_outs0", outs(0), 32'd0);
      check("reset_outs1", outs(1), 32'd0);
      reset_n = 1'b1;
      step();
      check("post_reset_outs0", outs(0), 32'd0);

      // Fault-free run, first cycles checked against the vector table.
      b0 = busy_tot[0];
      d0 = done_tot[0];
      q0 = ends.size();
      for (int k = 0; k < 10; k++) begin
         start = vecs[k].start;
         step();
         start = 1'b0;
         check($sformatf("vec%0d_flags", k),
               32'({busy[0], done[0], ag_reset[0], ag_preset[0], ag_en[0], ag_up_down[0],
                    mem_we[0], mem_re[0]}), 32'(vecs[k].flags));
         check($sformatf("vec%0d_wdata", k), 32'(wdata[0]), 32'(vecs[k].wdata));
         check($sformatf("vec%0d_addr", k), 32'(addr[0]), 32'(vecs[k].addr));
      end
      wait_done("pass_done", 200);
      step(); step(); step();
      check("pass_busy_cycles", 32'(busy_tot[0] - b0), 32'd66);
      check("pass_done_count", 32'(done_tot[0] - d0), 32'd1);
      check("pass_fail", 32'(fail[0]), 32'd0);
      check("pass_fail_stop", 32'(fail[1]), 32'd0);
      check("elem_end_count", 32'(ends.size() - q0), 32'd7);
      for (int e = 0; e < 6; e++)
         if (q0 + e + 1 < ends.size())
            check($sformatf("elem%0d_end_addr", e), 32'(ends[q0 + e + 1]), 32'(exp_ends[e]));

      // Stuck-at-0 fault: full run vs stop-on-fail instance.
      fault_en = 1'b1;
      b0 = busy_tot[0]; b1 = busy_tot[1];
      d0 = done_tot[0]; d1 = done_tot[1];
      waf = we_after_fail;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("fault_done", 200);
      step(); step(); step();
      check("fault_fail", 32'(fail[0]), 32'd1);
      check("fault_elem", 32'(fail_element[0]), 32'd2);
      check("fault_addr", 32'(fail_addr[0]), 32'd2);
      check("fault_data", 32'(fail_data[0]), 32'hFE);
      check("fault_busy_cycles", 32'(busy_tot[0] - b0), 32'd66);
      check("fault_done_count", 32'(done_tot[0] - d0), 32'd1);
      check("stop_fail", 32'(fail[1]), 32'd1);
      check("stop_elem", 32'(fail_element[1]), 32'd2);
      check("stop_addr", 32'(fail_addr[1]), 32'd2);
      check("stop_data", 32'(fail_data[1]), 32'hFE);
      check("stop_busy_cycles", 32'(busy_tot[1] - b1), 32'd27);
      check("stop_done_count", 32'(done_tot[1] - d1), 32'd1);
      check("stop_no_we_after_fail", 32'(we_after_fail - waf), 32'd0);

      // Sticky fail, start pulses while busy ignored.
      fault_en = 1'b0;
      step(); step(); step(); step(); step();
      check("sticky_fail", 32'(fail[0]), 32'd1);
      check("sticky_fail_stop", 32'(fail[1]), 32'd1);
      b0 = busy_tot[0];
      d0 = done_tot[0];
      start = 1'b1;
      step();
      start = 1'b0;
      check("accept_clears", 32'({fail[0], fail_addr[0], fail_element[0], fail_data[0]}), 32'd0);
      check("accept_busy", 32'(busy[0]), 32'd1);
      for (int k = 0; k < 5; k++) step();
      start = 1'b1; step(); start = 1'b0;
      for (int k = 0; k < 20; k++) step();
      start = 1'b1; step(); step(); start = 1'b0;
      wait_done("busy_start_done", 200);
      step(); step(); step();
      check("busy_start_cycles", 32'(busy_tot[0] - b0), 32'd66);
      check("busy_start_done_count", 32'(done_tot[0] - d0), 32'd1);
      check("busy_start_busy_after", 32'(busy[0]), 32'd0);

      // Abort inside E3 on a write op, with a failure already captured.
      fault_en = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      c = 0;
      while (!ag_preset[0] && c < 200) begin
         step();
         c++;
      end
      check("abort_reach_e3", 32'(ag_preset[0]), 32'd1);
      step(); step(); step();
      check("abort_pre_we", 32'(mem_we[0]), 32'd1);
      abort = 1'b1;
      #1;
      check("abort_strobes", 32'({mem_we[0], mem_re[0], ag_en[0], ag_reset[0], ag_preset[0]}), 32'd0);
      d0 = done_tot[0];
      step();
      abort = 1'b0;
      check("abort_idle", 32'({busy[0], done[0]}), 32'd0);
      check("abort_keep_fail", 32'({fail[0], fail_addr[0], fail_element[0], fail_data[0]}),
            32'({1'b1, 2'd2, 3'd2, 8'hFE}));
      for (int k = 0; k < 10; k++) step();
      check("abort_no_done", 32'(done_tot[0] - d0), 32'd0);
      fault_en = 1'b0;
      run_pass("after_abort");

      // Async reset in the middle of E1.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 6; k++) step();
      check("rst_pre_re", 32'(mem_re[0]), 32'd1);
      d0 = done_tot[0];
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_outs0", outs(0), 32'd0);
      check("rst_async_outs1", outs(1), 32'd0);
      step();
      reset_n = 1'b1;
      step();
      check("rst_no_done", 32'(done_tot[0] - d0), 32'd0);
      run_pass("after_reset");

      check("mutex_ag", 32'(mutex_err), 32'd0);
      check("idle_quiet", 32'(idle_err), 32'd0);
      check("stop_no_we_total", 32'(we_after_fail), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
